program_loader: RTL and testbench

//  Writer side of the SAP program memory. Accepts instruction items (opcode + operand) or raw data

---
 rtl/program_loader.sv | 185 ++++++++++++++++++
 tb/tb_program_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: writes a stream of instruction/data items into consecutive program RAM words
// while holding the CPU in clear. Define LOADER_READBACK_EN to verify each word via mem_rdata.
module program_loader #(
  parameter int ADDR_W   = 4,
  parameter int OPCODE_W = 3,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       reg_clr,
  input  logic                       load_start,
  input  logic [ADDR_W-1:0]          load_base,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_kind,
  input  logic [OPCODE_W-1:0]        in_opcode,
  input  logic [DATA_W-OPCODE_W-1:0] in_operand,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_wr,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       cpu_hold,
  output logic                       load_done,
  output logic                       load_err,
  output logic [1:0]                 err_code
);

  localparam logic [ADDR_W-1:0]   PTR_MAX      = {ADDR_W{1'b1}};
  localparam logic [OPCODE_W-1:0] OP_MAX       = OPCODE_W'(4);
  localparam logic [1:0]          ERR_OPCODE   = 2'd1;
  localparam logic [1:0]          ERR_OVERFLOW = 2'd2;
  localparam logic [1:0]          ERR_READBACK = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_CHECK,
    S_RELEASE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_wr_q, mem_wr_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [DATA_W-1:0]   item_word;
  logic                item_bad;
  logic                item_finished;

`ifndef LOADER_READBACK_EN
  logic rdata_unused;
  assign rdata_unused = ^mem_rdata;
`endif

  always_comb begin
    item_word = in_kind ? in_data : {in_opcode, in_operand};
    item_bad  = !in_kind && (in_opcode > OP_MAX);
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    last_d        = last_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wr_d      = 1'b0;
    cpu_hold_d    = cpu_hold_q;
    load_done_d   = 1'b0;
    load_err_d    = load_err_q;
    err_code_d    = err_code_q;
    item_finished = 1'b0;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (load_start) begin
          ptr_d      = load_base;
          cpu_hold_d = 1'b1;
          load_err_d = 1'b0;
          err_code_d = 2'd0;
          state_d    = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          last_d = in_last;
          if (item_bad) begin
            err_code_d = ERR_OPCODE;
            load_err_d = 1'b1;
            state_d    = S_ERROR;
          end else begin
            mem_addr_d  = ptr_q;
            mem_wdata_d = item_word;
            mem_wr_d    = 1'b1;
            state_d     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
`ifdef LOADER_READBACK_EN
        state_d = S_CHECK;
`else
        item_finished = 1'b1;
`endif
      end
      S_CHECK: begin
`ifdef LOADER_READBACK_EN
        // mem_addr still points at the word just written; RAM read is combinational
        if (mem_rdata != mem_wdata_q) begin
          err_code_d = ERR_READBACK;
          load_err_d = 1'b1;
          state_d    = S_ERROR;
        end else begin
          item_finished = 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_RELEASE: begin
        cpu_hold_d  = 1'b0;
        load_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Post-write bookkeeping; the pointer saturates into an error rather than wrapping
    if (item_finished) begin
      if (last_q) begin
        state_d = S_RELEASE;
      end else if (ptr_q == PTR_MAX) begin
        err_code_d = ERR_OVERFLOW;
        load_err_d = 1'b1;
        state_d    = S_ERROR;
      end else begin
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = S_ACCEPT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reg_clr) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      last_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_ready  = (state_q == S_ACCEPT);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random load sessions checked against a list-based model.
module tb_program_loader;
  localparam int ADDR_W   = 4;
  localparam int OPCODE_W = 3;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
`ifdef LOADER_READBACK_EN
  localparam int PERIOD = 3;
`else
  localparam int PERIOD = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reg_clr, load_start, in_valid, in_kind, in_last;
  logic [ADDR_W-1:0]    load_base;
  logic [OPCODE_W-1:0]  in_opcode;
  logic [4:0]           in_operand;
  logic [DATA_W-1:0]    in_data;
  logic                 in_ready, mem_wr, cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata, mem_rdata;
  logic [1:0]           err_code;

  program_loader dut (
    .clk(clk), .reg_clr(reg_clr), .load_start(load_start), .load_base(load_base),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_opcode(in_opcode),
    .in_operand(in_operand), .in_data(in_data), .in_last(in_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  // RAM model with an optional stuck-at-0 bit mask; every write is logged for the scoreboard
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DATA_W-1:0]        stuck_mask = '0;
  logic [ADDR_W+DATA_W-1:0] obs_q[$];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      mem[mem_addr] <= mem_wdata & ~stuck_mask;
      obs_q.push_back({mem_addr, mem_wdata});
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic       it_kind [8];
  logic [2:0] it_op   [8];
  logic [4:0] it_oper [8];
  logic [7:0] it_data [8];
  logic       it_last [8];
  int         n_items;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic drive_item(input int i);
    in_valid   = 1'b1;
    in_kind    = it_kind[i];
    in_opcode  = it_op[i];
    in_operand = it_oper[i];
    in_data    = it_data[i];
    in_last    = it_last[i];
  endtask

  task automatic run_session(input logic [3:0] base, input string name);
    logic [11:0] exp_w[$];
    logic [7:0]  word;
    logic [1:0]  exp_err;
    int          a, n_acc, w0, hold_bad, waited, prev_acc;
    // Reference: addresses count up from base, stop on last, bad opcode, readback fault or top of memory
    a = base; n_acc = 0; exp_err = 2'd0;
    for (int i = 0; i < n_items; i++) begin
      n_acc = i + 1;
      if (!it_kind[i] && it_op[i] > 3'd4) begin exp_err = 2'd1; break; end
      word = it_kind[i] ? it_data[i] : {it_op[i], it_oper[i]};
      exp_w.push_back({a[3:0], word});
      if ((word & stuck_mask) != 8'd0) begin exp_err = 2'd3; break; end
      if (it_last[i]) break;
      if (a == DEPTH - 1) begin exp_err = 2'd2; break; end
      a++;
    end

    w0 = obs_q.size();
    hold_bad = 0;
    prev_acc = 0;
    load_base = base; load_start = 1'b1;
    step();
    load_start = 1'b0;
    check({name, "_start_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({name, "_start_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_start_err"}, {29'd0, load_err, err_code}, 32'd0);

    for (int i = 0; i < n_acc; i++) begin
      drive_item(i);
      waited = 0;
      while (in_ready !== 1'b1 && waited < 10) begin
        if (cpu_hold !== 1'b1) hold_bad++;
        step();
        waited++;
      end
      if (waited >= 10) check({name, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
      step();
      if (i > 0) check({name, "_period"}, cycle - prev_acc, PERIOD);
      prev_acc = cycle;
    end

    for (int k = 0; k < PERIOD; k++) begin
      if (cpu_hold !== 1'b1 || load_done !== 1'b0) hold_bad++;
      if (exp_err == 2'd1 && in_ready !== 1'b0) hold_bad++;
      if (k < PERIOD - 1) step();
    end
    if (exp_err == 2'd0) begin
      step();
      check({name, "_done"}, {30'd0, load_done, cpu_hold}, 32'b10);
      check({name, "_done_err"}, {29'd0, load_err, err_code}, 32'd0);
      check({name, "_addr_hold"}, {28'd0, mem_addr}, {28'd0, exp_w[exp_w.size()-1][11:8]});
      in_valid = 1'b0;
      step();
      check({name, "_done_pulse"}, {30'd0, load_done, in_ready}, 32'd0);
    end else begin
      step();
      check({name, "_err"}, {28'd0, load_err, cpu_hold, err_code}, {28'd0, 2'b11, exp_err});
      in_kind = 1'b1; in_data = 8'h3C; in_last = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || load_err !== 1'b1) hold_bad++;
        step();
      end
      in_valid = 1'b0;
    end
    check({name, "_hold"}, hold_bad, 0);
    check({name, "_nwrites"}, obs_q.size() - w0, exp_w.size());
    for (int j = 0; j < exp_w.size(); j++) begin
      if (w0 + j < obs_q.size()) check({name, "_write"}, {20'd0, obs_q[w0+j]}, {20'd0, exp_w[j]});
    end
    $display("session %s base=%0d items=%0d writes=%0d err=%0d", name, base, n_acc, exp_w.size(), exp_err);
  endtask

  task automatic set_instr(input int i, input logic [2:0] op, input logic [4:0] oper, input logic last);
    it_kind[i] = 1'b0; it_op[i] = op; it_oper[i] = oper; it_data[i] = 8'h00; it_last[i] = last;
  endtask

  initial begin
    int w;
    reg_clr = 1'b1; load_start = 1'b0; load_base = '0; in_valid = 1'b0; in_kind = 1'b0;
    in_opcode = '0; in_operand = '0; in_data = '0; in_last = 1'b0;
    repeat (3) step();
    reg_clr = 1'b0;
    check("reset_outputs", {in_ready, mem_wr, cpu_hold, load_done, load_err, err_code, mem_addr, mem_wdata}, 32'd0);
    step();

    // Reset in the middle of a session
    load_base = 4'd5; load_start = 1'b1; step(); load_start = 1'b0;
    set_instr(0, 3'd1, 5'd7, 1'b0); drive_item(0);
    step();
    check("midreset_write", {31'd0, mem_wr}, 32'd1);
    reg_clr = 1'b1;
    step();
    w = obs_q.size();
    check("midreset_outputs", {in_ready, mem_wr, cpu_hold, load_done, load_err, err_code, mem_addr, mem_wdata}, 32'd0);
    reg_clr = 1'b0;
    repeat (4) step();
    check("midreset_nowrite", obs_q.size() - w, 0);
    check("midreset_idle", {30'd0, in_ready, cpu_hold}, 32'd0);
    in_valid = 1'b0;

    // Program LDA 9, ADD 10, OUT 0, HLT
    n_items = 4;
    set_instr(0, 3'd0, 5'd9, 1'b0); set_instr(1, 3'd1, 5'd10, 1'b0);
    set_instr(2, 3'd3, 5'd0, 1'b0); set_instr(3, 3'd4, 5'd0, 1'b1);
    run_session(4'd0, "program");

    // Overflow at top of memory
    n_items = 2;
    set_instr(0, 3'd2, 5'd3, 1'b0); set_instr(1, 3'd0, 5'd4, 1'b0);
    run_session(4'd15, "overflow");

    // Bad opcode, then a restart from the error state
    n_items = 1;
    set_instr(0, 3'd6, 5'd1, 1'b1);
    run_session(4'd2, "badop");
    n_items = 2;
    set_instr(0, 3'd0, 5'd14, 1'b0); set_instr(1, 3'd4, 5'd0, 1'b1);
    run_session(4'd2, "reload");

    // Raw data byte
    n_items = 1;
    it_kind[0] = 1'b1; it_op[0] = 3'd0; it_oper[0] = 5'd0; it_data[0] = 8'hA5; it_last[0] = 1'b1;
    run_session(4'd9, "rawdata");

`ifdef LOADER_READBACK_EN
    stuck_mask = 8'h01;
    it_data[0] = 8'h01;
    run_session(4'd4, "stuckbit");
    stuck_mask = 8'h00;
`endif

    for (int s = 0; s < 25; s++) begin
      logic [3:0] base;
      n_items = $urandom_range(1, 6);
      base = ($urandom % 3 == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 15));
      for (int i = 0; i < n_items; i++) begin
        it_kind[i] = 1'($urandom % 2);
        it_op[i]   = ($urandom % 10 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        it_oper[i] = 5'($urandom);
        it_data[i] = 8'($urandom);
        it_last[i] = (i == n_items - 1);
      end
      run_session(base, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
